// File: rtl/push_conditioner.sv
// push_conditioner: synchronize, debounce and auto-repeat five push buttons
module push_conditioner #(
  parameter int DEBOUNCE_CNT = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sample_en,
  input  logic [4:0] push,
  output logic [4:0] level,
  output logic [4:0] press,
  output logic [4:0] rel,
  output logic [4:0] rpt,
  output logic [4:0] step
);
  localparam logic [15:0] DB = 16'(DEBOUNCE_CNT);
  localparam logic [15:0] RD = 16'(REPEAT_DELAY);
  localparam logic [15:0] RR = 16'(REPEAT_RATE);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  logic [4:0] s1, s;
  // two-flop synchronizer on every raw button; only s feeds later logic
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) {s, s1} <= '0;
    else {s, s1} <= {s1, push};
  assign step = press | rpt;
  for (genvar i = 0; i < 5; i++) begin : g_bit
    logic [15:0] db_cnt, hold_cnt, hold_lim;
    logic lvl, prs, rls, rp, flip;
    state_t state;
    assign flip = sample_en && (s[i] != lvl) && (db_cnt + 16'd1 == DB);
    assign hold_lim = (state == DELAY) ? RD : RR;
    assign level[i] = lvl;
    assign press[i] = prs;
    assign rel[i] = rls;
    assign rpt[i] = rp;
    // debounce: count strobes while s differs from level, flip level at the terminal count
    always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
        db_cnt <= '0;
        lvl    <= 1'b0;
        prs    <= 1'b0;
        rls    <= 1'b0;
      end else begin
        prs    <= flip && !lvl;
        rls    <= flip && lvl;
        db_cnt <= (s[i] == lvl || flip) ? '0 : sample_en ? db_cnt + 16'd1 : db_cnt;
        lvl    <= flip ? ~lvl : lvl;
      end
    // repeat FSM: armed on the rising flip, first pulse after REPEAT_DELAY, then every REPEAT_RATE
    always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
        state    <= IDLE;
        hold_cnt <= '0;
        rp       <= 1'b0;
      end else begin
        rp <= 1'b0;
        if (flip) begin
          state    <= lvl ? IDLE : DELAY;
          hold_cnt <= '0;
        end else if (state != IDLE && sample_en) begin
          if (hold_cnt + 16'd1 == hold_lim) begin
            rp       <= 1'b1;
            hold_cnt <= '0;
            state    <= REPEAT;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
      end
  end
endmodule

// File: tb/tb_push_conditioner.sv
// tb_push_conditioner: table-driven scenarios checked cycle by cycle through an event scoreboard
module tb_push_conditioner;
  localparam int N = 100;
  logic clk = 1'b0, resetn = 1'b0, sample_en = 1'b0;
  logic [4:0] push = '0;
  logic [4:0] level, press, rel, rpt, step;
  int errors = 0, checks = 0, cyc = 0;
  bit mon = 1'b0;
  logic [4:0] push_v [N], lvl_v [N], pr_v [N], rl_v [N], rp_v [N];
  logic rst_v [N], se_v [N];
  typedef struct {int cyc; logic [4:0] pr; logic [4:0] rl; logic [4:0] rp;} ev_t;
  ev_t q[$];
  typedef struct {int scen; int b; int rise; int fall;} hold_t;
  hold_t tbl [6];
  ev_t e;

  push_conditioner #(.DEBOUNCE_CNT(4), .REPEAT_DELAY(10), .REPEAT_RATE(3)) dut (
    .clk(clk), .resetn(resetn), .sample_en(sample_en), .push(push),
    .level(level), .press(press), .rel(rel), .rpt(rpt), .step(step)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) if (mon) begin
    if (q.size() > 0 && q[0].cyc == cyc) e = q.pop_front();
    else e = '{cyc, 5'b0, 5'b0, 5'b0};
    check("level", level, lvl_v[cyc]);
    check("press", press, e.pr);
    check("release", rel, e.rl);
    check("rpt", rpt, e.rp);
    check("step", step, e.pr | e.rp);
  end

  task automatic clear();
    for (int c = 0; c < N; c++) begin
      push_v[c] = '0; lvl_v[c] = '0; pr_v[c] = '0; rl_v[c] = '0; rp_v[c] = '0;
      rst_v[c] = 1'b1; se_v[c] = 1'b1;
    end
    q.delete();
  endtask

  task automatic drive_hold(input int b, input int rise, input int fall);
    for (int c = rise; c < fall && c < N; c++) push_v[c][b] = 1'b1;
  endtask

  task automatic add_hold(input int b, input int p, input int r, input bit emit, input int first, input int per);
    pr_v[p][b] = 1'b1;
    for (int c = p; c < r && c < N; c++) lvl_v[c][b] = 1'b1;
    for (int t = p + first; t < r && t < N; t += per) rp_v[t][b] = 1'b1;
    if (emit && r < N) rl_v[r][b] = 1'b1;
  endtask

  task automatic run(input int len);
    for (int c = 0; c <= len; c++)
      if ((pr_v[c] | rl_v[c] | rp_v[c]) != 5'b0) q.push_back('{c, pr_v[c], rl_v[c], rp_v[c]});
    mon = 1'b1;
    for (int c = 0; c <= len; c++) begin
      cyc = c; push = push_v[c]; resetn = rst_v[c]; sample_en = se_v[c];
      @(posedge clk); #1;
    end
    mon = 1'b0;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missed_events actual=%0d pending required=0 (next at cyc %0d)", q.size(), q[0].cyc);
    end
  endtask

  initial begin
    int last;
    tbl[0] = '{0, 0, 0, 8};
    tbl[1] = '{1, 1, 0, 40};
    tbl[2] = '{2, 3, 0, 40};
    tbl[3] = '{2, 4, 0, 12};
    tbl[4] = '{3, 2, 2, 9};
    tbl[5] = '{3, 0, 5, 30};
    clear();
    for (int c = 0; c < 6; c++) rst_v[c] = 1'b0;
    for (int c = 0; c < 5; c++) push_v[c] = 5'h1f;
    run(10);
    for (int s = 0; s < 4; s++) begin
      clear();
      last = 0;
      for (int k = 0; k < 6; k++) if (tbl[k].scen == s) begin
        drive_hold(tbl[k].b, tbl[k].rise, tbl[k].fall);
        add_hold(tbl[k].b, tbl[k].rise + 6, tbl[k].fall + 6, 1'b1, 10, 3);
        if (tbl[k].fall + 6 > last) last = tbl[k].fall + 6;
      end
      run(last + 4);
    end
    clear();
    for (int k = 0; k < 5; k++) drive_hold(2, 4 * k, 4 * k + 3);
    run(30);
    clear();
    drive_hold(1, 0, 30);
    for (int c = 14; c < 17; c++) rst_v[c] = 1'b0;
    add_hold(1, 6, 14, 1'b0, 10, 3);
    add_hold(1, 23, 36, 1'b1, 10, 3);
    run(40);
    clear();
    for (int c = 0; c < N; c++) se_v[c] = (c % 4 == 3);
    drive_hold(0, 0, 60);
    add_hold(0, 16, 76, 1'b1, 40, 12);
    run(82);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/push_conditioner.md
PUSH_CONDITIONER -- requirements
Module: push_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 20: consecutive sample strobes a changed input must persist before the debounced level flips.
REQ-002 Parameter REPEAT_DELAY, default 500: sample strobes after a press before the first auto-repeat pulse.
REQ-003 Parameter REPEAT_RATE, default 100: sample strobes between subsequent auto-repeat pulses.
REQ-004 clk  input  1  system clock; every register in the block is clocked on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 sample_en  input  1  one-cycle debounce/repeat strobe (nominally 1 kHz), synchronous to clk.
REQ-007 push  input  5  raw, asynchronous push buttons, active-high: [0]=up, [1]=down, [2]=left, [3]=right, [4]=middle.
REQ-008 level  output  5  debounced button state, one bit per button.
REQ-009 press  output  5  one-cycle pulse on each debounced 0->1 transition.
REQ-010 release  output  5  one-cycle pulse on each debounced 1->0 transition.
REQ-011 rpt  output  5  one-cycle auto-repeat pulse while a button is held.
REQ-012 step  output  5  press OR rpt, per bit; this is the increment/move strobe for the time-set and alarm-set services.

Function
REQ-013 Each push bit SHALL pass through its own two-flop synchronizer, and all later logic SHALL use only the synchronized value (s).
REQ-014 The five buttons SHALL be fully independent; simultaneous activity on several bits SHALL give the same per-bit results as each bit alone.
REQ-015 Per-bit debounce counter, at least 16 bits wide:
- cleared in any cycle where s == level;
- incremented on each sample_en where s != level.
REQ-016 When a sample_en increment would bring the counter to DEBOUNCE_CNT:
- level SHALL toggle on that clock edge;
- the counter SHALL clear on that clock edge.
REQ-017 If s returns to the level value before the count is reached (a bounce), the counter SHALL clear and level, press and release SHALL not change.
REQ-018 Latency with sample_en tied high: level changes exactly 2+DEBOUNCE_CNT cycles after a stable raw edge.
REQ-019 press[i] (or release[i]) SHALL be high for exactly the single cycle in which level[i] first reads its new value.
REQ-020 Per-bit repeat state machine, states IDLE, DELAY, REPEAT:
- IDLE -> DELAY on press, with the hold counter set to 0;
- DELAY: on each sample_en, count; on reaching REPEAT_DELAY, pulse rpt, clear the counter and go to REPEAT;
- REPEAT: on each sample_en, count; on reaching REPEAT_RATE, pulse rpt and clear the counter;
- any state -> IDLE in the cycle release is asserted, with the hold counter cleared; rpt SHALL never fire in or after the release cycle.
REQ-021 The hold counter SHALL be at least 16 bits wide; wrap-around SHALL be impossible because the counter clears at its terminal count.
REQ-022 press and rpt for the same bit SHALL never be high in the same cycle; step is their bitwise OR.
REQ-023 No pulse SHALL be generated on cycles without sample_en, except the press, release and step pulses tied to a level change.
REQ-024 All outputs SHALL be registered, or SHALL be combinational functions of registers only.

Reset
REQ-025 While resetn=0, the block SHALL hold level=0, press=0, release=0, rpt=0 and step=0, with the synchronizers, all counters and all FSMs in their cleared state (FSMs in IDLE).
REQ-026 Reset asserted mid-debounce or mid-repeat SHALL abort the operation immediately, with no pulse emitted.
REQ-027 A button held across reset deassertion SHALL be treated as a new press: level rises and press pulses after the REQ-018 latency.

Verification
Common settings for all scenarios: DEBOUNCE_CNT=4, REPEAT_DELAY=10, REPEAT_RATE=3, sample_en=1 unless stated.
REQ-028 Clean press of push[0] held for 8 cycles, then released -> level[0] rises at cycle 6 with press[0] a one-cycle pulse; release[0] pulses 6 cycles after the falling edge; rpt stays 0.
REQ-029 Bounce: push[2] toggles high 3 cycles / low 1 cycle, repeated 5 times, then low -> level, press and release all stay 0.
REQ-030 Hold push[1] for 40 cycles -> press at cycle 6, rpt at 16, 19, 22, ... up to release; step pulses at 6, 16, 19, ...; no rpt in or after the release cycle.
REQ-031 Simultaneous hold of push[3] and push[4], with push[4] released after 12 cycles -> both press pulses in the same cycle; push[3] keeps repeating unaffected.
REQ-032 resetn pulsed low at cycle 14 of a hold, raw input still high -> all outputs 0 during reset; press reasserts 6 cycles after deassertion; no rpt or release fires during the reset.
REQ-033 sample_en strobing every 4th cycle with DEBOUNCE_CNT=4 -> level rises within 2+16 cycles of the raw edge; no pulses occur in other cycles except the change-tied pulses.
